// File: rtl/icache_sa.sv
// icache_sa: set-associative, multi-word-line instruction cache with LRU, burst refill, uncached bypass and flush.
// Latency: hits return inst combinationally in IDLE; a miss stalls 1 + N beats (each beat waits for mem_rvalid).
// Backpressure: icache_stall holds fetch; mem_req is held until mem_rvalid, and dropping it cancels the beat.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   addr               - word-aligned fetch PC
//   predict_fail       - cancels an in-flight miss/uncached fetch
//   flush              - invalidate all sets, one set per cycle
//   inst, icache_stall - instruction out (valid when icache_stall=0), fetch hold
//   mem_req, mem_addr  - single-beat read request towards instruction memory
//   mem_rdata, mem_rvalid - read data and beat-accept strobe
module icache_sa #(
    parameter int          INDEX_WIDTH     = 4,
    parameter int          LINE_WORDS_LOG2 = 2,
    parameter int          WAYS            = 2,
    parameter logic [15:0] UNCACHED_HI     = 16'h1c09
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        predict_fail,
    input  logic        flush,
    output logic [31:0] inst,
    output logic        icache_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
);
    localparam int SETS    = 1 << INDEX_WIDTH;
    localparam int N       = 1 << LINE_WORDS_LOG2;
    localparam int IDX_LSB = LINE_WORDS_LOG2 + 2;
    localparam int TAG_LSB = IDX_LSB + INDEX_WIDTH;
    localparam int TAG_W   = 32 - TAG_LSB;
    localparam int LINE_W  = 32 - IDX_LSB;

    typedef enum logic [2:0] {S_IDLE, S_REFILL, S_UNC, S_UDONE, S_FLUSH} state_t;

    state_t                     state_q, state_d;
    logic [LINE_WORDS_LOG2-1:0] beat_q, beat_d;
    logic [INDEX_WIDTH-1:0]     fcnt_q, fcnt_d;
    logic [LINE_W-1:0]          line_q, line_d;    // line address (tag+index) being refilled
    logic                       victim_q, victim_d;
    logic [31:0]                ubuf_q, ubuf_d;

    // LRU bit of a set names the way to evict next.
    logic [SETS-1:0]  valid_q [WAYS];
    logic [SETS-1:0]  lru_q;
    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    logic [31:0]      data_q  [WAYS][SETS][N];

    logic [LINE_WORDS_LOG2-1:0] a_off;
    logic [INDEX_WIDTH-1:0]     a_idx;
    logic [TAG_W-1:0]           a_tag;
    logic                       a_unc;
    logic [INDEX_WIDTH-1:0]     l_idx;
    logic [TAG_W-1:0]           l_tag;

    assign a_off = addr[IDX_LSB-1:2];
    assign a_idx = addr[TAG_LSB-1:IDX_LSB];
    assign a_tag = addr[31:TAG_LSB];
    assign a_unc = (addr[31:16] == UNCACHED_HI);
    assign l_idx = line_q[INDEX_WIDTH-1:0];
    assign l_tag = line_q[LINE_W-1:INDEX_WIDTH];

    logic        hit;
    logic        hit_way;
    logic [31:0] hit_word;
    logic        victim;

    always_comb begin
        hit      = 1'b0;
        hit_way  = 1'b0;
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][a_idx] && tag_q[w][a_idx] == a_tag) begin
                hit      = 1'b1;
                hit_way  = 1'(w);
                hit_word = data_q[w][a_idx][a_off];
            end
        end
    end

    // First invalid way wins (way0 first); with both ways valid fall back to LRU.
    always_comb begin
        logic found;
        found  = 1'b0;
        victim = (WAYS > 1) ? lru_q[a_idx] : 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid_q[w][a_idx]) begin
                victim = 1'(w);
                found  = 1'b1;
            end
        end
    end

    logic hit_upd, alloc, word_we, line_done, flush_clr;

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        fcnt_d       = fcnt_q;
        line_d       = line_q;
        victim_d     = victim_q;
        ubuf_d       = ubuf_q;
        inst         = '0;
        icache_stall = 1'b0;
        mem_req      = 1'b0;
        mem_addr     = '0;
        hit_upd      = 1'b0;
        alloc        = 1'b0;
        word_we      = 1'b0;
        line_done    = 1'b0;
        flush_clr    = 1'b0;

        if (flush) begin
            // Entering (or restarting) the flush walk abandons any outstanding beat.
            state_d      = S_FLUSH;
            fcnt_d       = '0;
            beat_d       = '0;
            icache_stall = (state_q == S_FLUSH);
            if (state_q == S_IDLE && hit && !a_unc) begin
                inst = hit_word;
            end else if (state_q == S_UDONE) begin
                inst = ubuf_q;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (a_unc) begin
                        if (!predict_fail) begin
                            icache_stall = 1'b1;
                            state_d      = S_UNC;
                        end
                    end else if (hit) begin
                        inst    = hit_word;
                        hit_upd = 1'b1;
                    end else if (!predict_fail) begin
                        icache_stall = 1'b1;
                        alloc        = 1'b1;
                        victim_d     = victim;
                        line_d       = addr[31:IDX_LSB];
                        beat_d       = '0;
                        state_d      = S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (predict_fail) begin
                        // Victim stays invalid: a partial line is never exposed.
                        beat_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        icache_stall = 1'b1;
                        mem_req      = 1'b1;
                        mem_addr     = {line_q, beat_q, 2'b00};
                        if (mem_rvalid) begin
                            word_we = 1'b1;
                            beat_d  = beat_q + 1'b1;
                            if (&beat_q) begin
                                line_done = 1'b1;
                                state_d   = S_IDLE;
                            end
                        end
                    end
                end
                S_UNC: begin
                    if (predict_fail) begin
                        state_d = S_IDLE;
                    end else begin
                        icache_stall = 1'b1;
                        mem_req      = 1'b1;
                        mem_addr     = addr;
                        if (mem_rvalid) begin
                            ubuf_d  = mem_rdata;
                            state_d = S_UDONE;
                        end
                    end
                end
                S_UDONE: begin
                    inst    = ubuf_q;
                    state_d = S_IDLE;
                end
                S_FLUSH: begin
                    icache_stall = 1'b1;
                    flush_clr    = 1'b1;
                    fcnt_d       = fcnt_q + 1'b1;
                    if (&fcnt_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (rst) begin
            inst         = '0;
            icache_stall = 1'b0;
            mem_req      = 1'b0;
            mem_addr     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            beat_q   <= '0;
            fcnt_q   <= '0;
            line_q   <= '0;
            victim_q <= 1'b0;
            ubuf_q   <= '0;
            lru_q    <= '0;
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
            end
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            fcnt_q   <= fcnt_d;
            line_q   <= line_d;
            victim_q <= victim_d;
            ubuf_q   <= ubuf_d;
            if (flush_clr) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[w][fcnt_q] <= 1'b0;
                end
                lru_q[fcnt_q] <= 1'b0;
            end
            if (alloc) begin
                valid_q[victim][a_idx] <= 1'b0;
            end
            if (line_done) begin
                valid_q[victim_q][l_idx] <= 1'b1;
                if (WAYS > 1) lru_q[l_idx] <= ~victim_q;
            end
            if (hit_upd && WAYS > 1) begin
                lru_q[a_idx] <= ~hit_way;
            end
        end
    end

    // Data and tags are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (word_we) begin
            data_q[victim_q][l_idx][beat_q] <= mem_rdata;
        end
        if (line_done) begin
            tag_q[victim_q][l_idx] <= l_tag;
        end
    end
endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: directed plus randomized checks of icache_sa against a line-level LRU model.
// Latency: memory responder answers each requested beat after mem_lat wait cycles.
// Backpressure: icache_stall is counted per fetch; mem_rvalid only while mem_req is high.
module tb_icache_sa;
    localparam int SETS = 16;
    localparam int N    = 4;
    localparam int WAYS = 2;

    logic        clk = 1'b0;
    logic        rst, predict_fail, flush, mem_rvalid;
    logic [31:0] addr, mem_rdata;
    logic [31:0] inst, mem_addr;
    logic        icache_stall, mem_req;

    always #5 clk = ~clk;

    icache_sa dut (
        .clk(clk), .rst(rst), .addr(addr), .predict_fail(predict_fail), .flush(flush),
        .inst(inst), .icache_stall(icache_stall), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          mem_lat = 0;
    int          wcnt = 0;
    logic        obs_stall, obs_req;
    logic [31:0] obs_inst;
    logic [31:0] beats[$];
    // Cached lines (addr>>4) in global most-recently-used-first order.
    int unsigned lines[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5A5A5A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int find_line(input int unsigned ln);
        foreach (lines[i]) if (lines[i] == ln) return i;
        return -1;
    endfunction

    // A set holds at most WAYS lines; a miss into a full set drops its least recently used line.
    task automatic model_evict(input int unsigned ln);
        int cnt = 0;
        int last = -1;
        foreach (lines[i]) begin
            if ((lines[i] & 15) == (ln & 15)) begin
                cnt++;
                last = i;
            end
        end
        if (cnt >= WAYS) lines.delete(last);
    endtask

    task automatic model_touch(input int unsigned ln);
        int i;
        i = find_line(ln);
        if (i >= 0) lines.delete(i);
        lines.push_front(ln);
    endtask

    // One clock: inputs already driven; respond as memory and sample at negedge.
    task automatic cycle();
        @(negedge clk);
        if (mem_req) begin
            if (wcnt >= mem_lat) begin
                mem_rvalid = 1'b1;
                mem_rdata  = memf(mem_addr);
                wcnt       = 0;
                beats.push_back(mem_addr);
            end else begin
                mem_rvalid = 1'b0;
                wcnt++;
            end
        end else begin
            mem_rvalid = 1'b0;
            wcnt       = 0;
        end
        obs_stall = icache_stall;
        obs_req   = mem_req;
        obs_inst  = inst;
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] a, input string tag, output int st);
        logic [31:0] expb[$];
        int          exp_st;
        bit          unc, hit, match;
        int unsigned ln;
        ln  = a >> 4;
        unc = (a[31:16] == 16'h1c09);
        hit = !unc && (find_line(ln) >= 0);
        if (unc) begin
            exp_st = 2 + mem_lat;
            expb.push_back(a);
        end else if (hit) begin
            exp_st = 0;
        end else begin
            exp_st = 1 + N * (mem_lat + 1);
            for (int k = 0; k < N; k++) expb.push_back((a & 32'hFFFF_FFF0) + 32'(4 * k));
            model_evict(ln);
        end
        if (!unc) model_touch(ln);
        beats.delete();
        addr = a;
        st   = 0;
        cycle();
        while (obs_stall && st < 300) begin
            st++;
            cycle();
        end
        chk({tag, "_stalls"}, st, exp_st);
        chk({tag, "_inst"}, obs_inst, memf(a));
        match = (beats.size() == expb.size());
        if (match) foreach (expb[i]) if (beats[i] !== expb[i]) match = 1'b0;
        chk({tag, "_beats"}, 32'(match), 1);
    endtask

    // Called after the cycle that raised flush; predict_fail is held so the
    // post-flush miss does not stall and the FLUSH stall window is measurable.
    task automatic flush_wait(input string tag);
        int n = 0;
        bit any_req = 1'b0;
        flush        = 1'b0;
        predict_fail = 1'b1;
        cycle();
        while (obs_stall && n < 100) begin
            n++;
            if (obs_req) any_req = 1'b1;
            cycle();
        end
        predict_fail = 1'b0;
        chk({tag, "_cycles"}, n, 16);
        chk({tag, "_noreq"}, 32'(any_req), 0);
        lines.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        logic [31:0] a;
        int unsigned r, ln;

        rst = 1'b1; flush = 1'b0; predict_fail = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = '0; addr = 32'h1c000004;
        @(posedge clk); #1;
        cycle();
        chk("rst_stall", 32'(obs_stall), 0);
        chk("rst_req", 32'(obs_req), 0);
        chk("rst_inst", obs_inst, 0);
        rst = 1'b0;
        lines.delete();

        // Cold miss, zero-wait memory.
        mem_lat = 0;
        do_fetch(32'h1c000004, "cold", st);
        chk("cold_n5", st, 5);
        chk("cold_data", obs_inst, 32'hB9A5A5A1);
        do_fetch(32'h1c00000c, "cold_hit", st);
        chk("cold_hit_n0", st, 0);

        // LRU in set 0.
        do_fetch(32'h1c000000, "lru_a", st);
        do_fetch(32'h1c000100, "lru_b", st);
        do_fetch(32'h1c000000, "lru_a2", st);
        do_fetch(32'h1c000200, "lru_c", st);
        do_fetch(32'h1c000000, "lru_a3", st);
        chk("lru_a3_hit", st, 0);
        do_fetch(32'h1c000100, "lru_b2", st);
        chk("lru_b2_miss", st, 5);

        // Uncached: rvalid on the third request cycle; a repeat fetch re-requests.
        mem_lat = 2;
        do_fetch(32'h1c090010, "unc1", st);
        chk("unc1_n4", st, 4);
        do_fetch(32'h1c090010, "unc2", st);
        chk("unc2_n4", st, 4);

        // predict_fail on the second beat.
        mem_lat = 0;
        addr = 32'h1c000340;
        cycle();
        cycle();
        predict_fail = 1'b1;
        cycle();
        chk("pf_req", 32'(obs_req), 0);
        chk("pf_stall", 32'(obs_stall), 0);
        predict_fail = 1'b0;
        model_evict(32'h1c000340 >> 4);
        do_fetch(32'h1c000340, "pf_refetch", st);
        chk("pf_refetch_n5", st, 5);

        // Flush after filling three lines.
        do_fetch(32'h1c000410, "fl_a", st);
        do_fetch(32'h1c000520, "fl_b", st);
        do_fetch(32'h1c000630, "fl_c", st);
        addr  = 32'h1c000410;
        flush = 1'b1;
        cycle();
        flush_wait("flush");
        do_fetch(32'h1c000410, "post_fl_a", st);
        chk("post_fl_a_miss", st, 5);
        do_fetch(32'h1c000520, "post_fl_b", st);
        do_fetch(32'h1c000630, "post_fl_c", st);

        // Reset mid-refill.
        mem_lat = 1;
        addr = 32'h1c000750;
        cycle(); cycle(); cycle();
        rst = 1'b1;
        cycle();
        chk("rst_rf_stall", 32'(obs_stall), 0);
        chk("rst_rf_req", 32'(obs_req), 0);
        chk("rst_rf_inst", obs_inst, 0);
        rst = 1'b0;
        lines.delete();
        do_fetch(32'h1c000410, "rst_rf_cold", st);
        chk("rst_rf_cold_n9", st, 9);

        // Reset mid-flush.
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle(); cycle();
        rst = 1'b1;
        cycle();
        chk("rst_fl_stall", 32'(obs_stall), 0);
        chk("rst_fl_req", 32'(obs_req), 0);
        rst = 1'b0;
        lines.delete();
        do_fetch(32'h1c000410, "rst_fl_cold", st);
        chk("rst_fl_cold_n9", st, 9);

        // flush and predict_fail together mid-refill: flush wins.
        mem_lat = 0;
        addr = 32'h1c000860;
        cycle(); cycle();
        flush = 1'b1;
        predict_fail = 1'b1;
        cycle();
        chk("flpf_req", 32'(obs_req), 0);
        flush_wait("flpf");

        // Randomized traffic over a few conflicting sets.
        for (int i = 0; i < 80; i++) begin
            mem_lat = $urandom_range(0, 3);
            r = $urandom_range(0, 19);
            if (r < 2) a = 32'h1c090000 | 32'($urandom_range(0, 63) << 2);
            else a = 32'h1c000000 + 32'($urandom_range(0, 2) * 256 + $urandom_range(0, 3) * 16
                                        + $urandom_range(0, 3) * 4);
            ln = a >> 4;
            if (r == 4) begin
                addr  = a;
                flush = 1'b1;
                cycle();
                flush_wait("rnd_flush");
            end else if (r >= 2 && r < 4 && find_line(ln) < 0) begin
                addr = a;
                cycle();
                chk("rnd_ab_miss", 32'(obs_stall), 1);
                for (int k = 0; k < int'($urandom_range(0, 2)); k++) cycle();
                predict_fail = 1'b1;
                cycle();
                chk("rnd_ab_req", 32'(obs_req), 0);
                chk("rnd_ab_stall", 32'(obs_stall), 0);
                predict_fail = 1'b0;
                model_evict(ln);
            end else begin
                do_fetch(a, "rnd", st);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
- Set-associative, multi-word-line instruction cache between the pipeline fetch stage and instruction memory.
- Generalises the direct-mapped single-word icache with configurable sets, line length and associativity (1 or 2 ways, LRU replacement).
- Adds a burst refill handshake with variable memory latency, a bypass path for an uncached region, a sequential flush, and refill abort on branch mispredict.

Parameters:
- INDEX_WIDTH, 4, log2 of set count (SETS = 2^INDEX_WIDTH).
- LINE_WORDS_LOG2, 2, log2 of 32-bit words per line (N = 2^LINE_WORDS_LOG2).
- WAYS, 2, associativity; legal values 1 or 2.
- UNCACHED_HI, 16'h1c09, addr[31:16] value that selects the uncached region.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- addr  in  32  fetch PC; word aligned.
- predict_fail  in  1  mispredict; cancels the current miss or refill.
- flush  in  1  invalidate the whole cache (fence.i).
- inst  out  32  fetched instruction; valid when icache_stall=0.
- icache_stall  out  1  holds the fetch stage.
- mem_req  out  1  memory read request, held until mem_rvalid.
- mem_addr  out  32  word address of the current beat.
- mem_rdata  in  32  read data.
- mem_rvalid  in  1  beat accepted and data valid this cycle; ignored when mem_req=0. Dropping mem_req cancels the outstanding beat.

Behaviour:
- Address split:
  - offset = addr[LINE_WORDS_LOG2+1:2]
  - index = addr[INDEX_WIDTH+LINE_WORDS_LOG2+1 : LINE_WORDS_LOG2+2]
  - tag = remaining upper bits, 24 bits at defaults.
- Storage: per way/set a valid bit, tag, and N data words; one LRU bit per set (unused when WAYS=1).
- Reset (sync): all valid and LRU bits cleared, state=IDLE, beat counter=0. While rst=1: mem_req=0, icache_stall=0, inst=0.
- Hit: combinational in IDLE. inst = matching way's word[offset], icache_stall=0, zero added latency. On posedge, LRU[index] is set to point at the non-hit way.
- States:
  - IDLE:
    - Cached miss: stall=1, go to REFILL. Victim = first invalid way (way0 first), otherwise the LRU way. Clear the victim's valid bit and latch line base and victim.
    - Uncached address: stall=1, go to UNC.
    - Miss or uncached with predict_fail=1: no transition, stall=0, inst don't-care.
  - REFILL:
    - mem_req=1, mem_addr = line base + 4*beat.
    - Each mem_rvalid: write mem_rdata into victim word[beat], beat++.
    - On the last beat (beat=N-1 with rvalid): set valid and tag, LRU = other way, beat=0, go to IDLE. The next cycle hits.
    - stall=1 throughout.
    - With zero-wait memory (rvalid same cycle as req), a miss stalls exactly N+1 cycles.
  - UNC:
    - mem_req=1, mem_addr=addr, stall=1.
    - On mem_rvalid, latch data into ubuf and go to UDONE.
    - Nothing is written into the cache.
  - UDONE: inst=ubuf, stall=0 for exactly one cycle, then IDLE. If addr is unchanged and still uncached, the fetch repeats.
  - FLUSH:
    - Counter walks sets 0..SETS-1, clearing valid and LRU of one set per cycle.
    - stall=1, mem_req=0.
    - After set SETS-1, go to IDLE; flush takes SETS cycles.
- Priority each cycle: rst > flush > predict_fail > normal.
  - flush in any state, including mid-refill or mid-UNC, goes to FLUSH and abandons the outstanding beat.
  - predict_fail in REFILL or UNC: mem_req drops that cycle, stall=0, state goes to IDLE. The victim stays invalid (partial line never valid) and beat resets to 0.
  - predict_fail in UDONE: ignored.
  - flush asserted in FLUSH: counter restarts at 0.
- Beat counter is LINE_WORDS_LOG2 bits and wraps only on line completion. mem_addr never crosses the line boundary.
- WAYS=1: victim is always way0 and LRU logic is inert.

Test Plan:
- Cold miss at addr 0x1c000004, zero-wait memory returning mem_rdata=addr^0xA5A5A5A5 -> mem_addr sequence 0x1c000000/04/08/0c, icache_stall high 5 cycles, then inst=0xB9A5A5A1 with stall=0. A fetch of 0x1c00000c hits with no stall.
- Conflict/LRU in set 0: fill 0x1c000000, fill 0x1c000100, re-hit 0x1c000000, miss 0x1c000200 -> evicts the 0x1c000100 line (way1). Refetch 0x1c000000 hits; refetch 0x1c000100 misses.
- Uncached 0x1c090010 with mem_rvalid after 3 cycles -> single beat at 0x1c090010, stall high 4 cycles. UDONE outputs the data for one cycle. No cache line becomes valid; a second fetch re-requests.
- predict_fail on the 2nd beat of a refill -> mem_req low and stall=0 that cycle, state IDLE. Refetching the same address performs a full 4-beat refill.
- flush after filling 3 lines -> stall high exactly 16 cycles with mem_req=0. All prior addresses then miss.
- rst asserted mid-refill and mid-flush -> next cycle mem_req=0, stall=0. The first fetch afterwards is a cold miss. flush+predict_fail together -> FLUSH entered.
